mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-port 12-bit MemoryQ RAM between two requesters: instruction fetch (port A) and data access (port B).
//   Each port uses a req/ack handshake. The arbiter sequences one access at a time, drives the RAM address, data and
//   write-enable pins, waits out the RAM read latency, and returns read data to the granted port.
// PARAMETERS
//   ADDR_W   12   address width (RAM depth 2**ADDR_W)
//   DATA_W   12   data word width
//   RD_LAT   1    edges from RAM address sample to valid mem_q; legal 1..4
// PORTS
//   clk          in   1       clock; all logic on posedge
//   rst_n        in   1       asynchronous active-low reset
//   a_req        in   1       port A request; addr/we/wdata held stable while high
//   a_we         in   1       port A write (1) / read (0)
//   a_addr       in   ADDR_W  port A address
//   a_wdata      in   DATA_W  port A write data
//   a_ack        out  1       port A completion, one-cycle pulse
//   a_rdata      out  DATA_W  port A read data, valid with a_ack, held until next A read ack
//   b_req/b_we/b_addr/b_wdata/b_ack/b_rdata  same as port A, for port B
//   mem_address  out  ADDR_W  to RAM address
//   mem_data     out  DATA_W  to RAM data
//   mem_wren     out  1       to RAM wren
//   mem_q        in   DATA_W  from RAM q
//   busy         out  1       high in any state other than IDLE
//   gnt_b        out  1       owner of current or last access (0=A, 1=B)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; all outputs 0; last-grant register = B, so A wins the first tie.
//   FSM states: IDLE -> ACCESS -> (WAIT, reads only) -> RESP -> IDLE.
//   IDLE: with no req, stay. With one req, grant it. With both, grant the port not granted last (round-robin).
//     At the grant edge E0, register mem_address/mem_data from the winner, set gnt_b, and go to ACCESS.
//   ACCESS (one cycle): mem_wren = winner's we. The RAM samples at edge E1. On a write go to RESP; on a read go to WAIT.
//   WAIT: counter loaded with RD_LAT-1; decrement per cycle; leave at 0.
//     At edge E(1+RD_LAT), capture mem_q into the winner's rdata and go to RESP.
//   RESP (one cycle): the winner's ack = 1 (registered). Then go to IDLE. busy = 0 only in IDLE.
//   Latency (req first seen at E0): write ack high between E1 and E2; read ack high between E(1+RD_LAT) and E(2+RD_LAT).
//   Requester drops req at the edge that ends its ack cycle. req still high in the following IDLE = a new request.
//   mem_wren is high only in ACCESS; never two consecutive cycles.
//   mem_address/mem_data hold their last value until the next grant.
//   The other port's rdata is never disturbed. The losing port waits with req held; no request is dropped.
//   Both ports requesting continuously alternate A,B,A,B. Max wait = one full access of the other port.
//   req/addr changes while granted and not yet acked are ignored; the values latched at E0 are used.
//   Reset mid-operation: the in-flight access is abandoned. No ack is issued and mem_wren drops immediately.
//     A write already sampled at E1 stays in RAM.
//   Width rules: no arithmetic on data. The WAIT counter is 2 bits (covers RD_LAT<=4).
// STRUCTURE
//   Shared package/header mem_arb_pkg: FSM state encodings (IDLE, ACCESS, WAIT, RESP), port IDs PORT_A=0 / PORT_B=1,
//     default ADDR_W/DATA_W.
//   Sub-module rr_arb2: two-input round-robin picker holding the last-grant flop; inputs req[1:0] and an update strobe;
//     outputs a one-hot grant.
//   Top level: FSM, latency counter, memory-side registers, per-port rdata/ack registers.
// TESTING (MemoryQ instance, RD_LAT=1 unless stated)
//   1. Hold rst_n=0 for 3 cycles with both reqs high -> all outputs 0, busy=0, no mem_wren; first grant after release goes to A.
//   2. RAM[0x000]=0x0A8; A read 0x000 -> a_ack high between E2 and E3; a_rdata=0x0A8; b_ack stays 0.
//   3. B write 0x010<-0xF0F, then A read 0x010 -> mem_wren high exactly 1 cycle; b_ack between E1 and E2; a_rdata=0xF0F.
//   4. A read 0x001 and B read 0x010 raised in the same cycle, held through 3 acks each ->
//      ack order A,B,A,B,A,B; each rdata correct; no lost requests.
//   5. Drop rst_n during WAIT of an A read -> no a_ack; outputs 0 asynchronously;
//      a fresh B read after release completes with normal latency.
//   6. RD_LAT=3 build, A read 0x000 -> a_ack high between E4 and E5; a_rdata=0x0A8; busy high from E0 to E5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the MemoryQ port arbiter.
//   arb_state_t : FSM states IDLE -> ACCESS -> (WAIT) -> RESP
//   PORT_A/B    : requester indices (A = instruction fetch, B = data access)
//   *_W_DEF     : default address/data widths of the MemoryQ RAM
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 12;

  localparam int unsigned PORT_A = 0;
  localparam int unsigned PORT_B = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests, index PORT_A / PORT_B
//   update     : strobe; records the current winner as last grant
//   gnt[1:0]   : one-hot grant (combinational)
// The last-grant flop resets to B so that A wins the first tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (update) begin
      last_b <= gnt[PORT_B];
    end
  end

  always_comb begin
    gnt = '0;
    if (req[PORT_A] && req[PORT_B]) begin
      // Tie: favour the port that did not win last time.
      if (last_b) begin
        gnt[PORT_A] = 1'b1;
      end else begin
        gnt[PORT_B] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port MemoryQ RAM between port A (instruction fetch)
// and port B (data access), one req/ack transaction at a time.
//   clk, rst_n              : clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata : port A request, held stable while a_req high
//   a_ack, a_rdata          : port A one-cycle completion pulse, read data
//   b_*                     : same for port B
//   mem_address/mem_data/mem_wren : RAM address, write data, write enable
//   mem_q                   : RAM read data, valid RD_LAT edges after address sample
//   busy                    : high whenever the FSM is not idle
//   gnt_b                   : owner of the current/last access (0 = A, 1 = B)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              gnt_b
);

  // WAIT counter start value; two bits cover RD_LAT 1..4.
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  arb_state_t state;
  logic [1:0] cnt;
  logic       we_q;
  logic [1:0] gnt;
  logic       grant_en;

  assign grant_en = (state == ST_IDLE) && (a_req || b_req);

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({b_req, a_req}),
    .update (grant_en),
    .gnt    (gnt)
  );

  assign busy = (state != ST_IDLE);

  // Decoded from state so the enable drops the instant reset asserts.
  assign mem_wren = (state == ST_ACCESS) && we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      gnt_b       <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant_en) begin
            gnt_b       <= gnt[PORT_B];
            mem_address <= gnt[PORT_A] ? a_addr  : b_addr;
            mem_data    <= gnt[PORT_A] ? a_wdata : b_wdata;
            we_q        <= gnt[PORT_A] ? a_we    : b_we;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            a_ack <= ~gnt_b;
            b_ack <= gnt_b;
            state <= ST_RESP;
          end else begin
            cnt   <= LAT_M1;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            if (gnt_b) begin
              b_rdata <= mem_q;
            end else begin
              a_rdata <= mem_q;
            end
            a_ack <= ~gnt_b;
            b_ack <= gnt_b;
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
